mapa_mem: RTL
=============

MAPA_MEM -- requirements
Module: mapa_mem

Interface
REQ-001 The module SHALL declare parameter MAP_W, default 40, meaning map width in blocks (screen width / block size).
REQ-002 The module SHALL declare parameter MAP_H, default 30, meaning map height in blocks.
REQ-003 The module SHALL declare parameter COLOR_BITS, default 6, meaning colour word width.
REQ-004 Ports SHALL be, clock and reset first:
  clk       in   1           single system clock, all logic on rising edge
  reset_n   in   1           reset, synchronous, active-low
  mapa_x    in   10          block column requested by the renderer
  mapa_y    in   10          block row requested by the renderer
  mapa_read in   1           read strobe from the renderer
  mapa_cor  out  COLOR_BITS  colour of the requested block
  mapa_vld  out  1           mapa_cor valid, one-cycle pulse
  wr_en     in   1           game-logic write request
  wr_x      in   10          write column
  wr_y      in   10          write row
  wr_cor    in   COLOR_BITS  write colour
  wr_ready  out  1           write accepted this cycle when high with wr_en
  clr_req   in   1           request to fill the whole map with clr_cor
  clr_cor   in   COLOR_BITS  fill colour, sampled with clr_req
  busy      out  1           high while a fill sweep is in progress

Function
REQ-005 Storage SHALL be MAP_W*MAP_H words of COLOR_BITS, index = y*MAP_W + x, index width = clog2(MAP_W*MAP_H).
REQ-006 FSM SHALL have states IDLE and CLEAR; busy = (state == CLEAR).
REQ-007 Read latency SHALL be exactly 1 cycle: mapa_read high at edge N -> mapa_cor and mapa_vld=1 after edge N+1; mapa_vld low otherwise.
REQ-008 Reads SHALL be served in every state, one per cycle, back-to-back without bubbles.
REQ-009 A read with mapa_x >= MAP_W or mapa_y >= MAP_H SHALL return 0 with mapa_vld=1 and no memory access.
REQ-010 mapa_cor SHALL hold its last value while mapa_vld is low.
REQ-011 wr_ready SHALL equal (state == IDLE); a write is committed at the edge where wr_en and wr_ready are both high.
REQ-012 An out-of-range write SHALL be accepted (handshake completes) and discarded.
REQ-013 A read and write to the same cell in the same cycle SHALL return the old value (read-before-write).
REQ-014 In IDLE, clr_req SHALL latch clr_cor, zero the sweep counter, and enter CLEAR at the next edge; a same-cycle wr_en is still committed.
REQ-015 In CLEAR, one cell per cycle SHALL be written with the latched colour, indices 0 to MAP_W*MAP_H-1 ascending; after the last cell the FSM SHALL return to IDLE (sweep = MAP_W*MAP_H cycles).
REQ-016 Reads during CLEAR SHALL return current memory contents (swept cells show the fill colour, unswept cells the old value).
REQ-017 clr_req during CLEAR SHALL re-latch clr_cor and restart the sweep at index 0.

Reset
REQ-018 With reset_n low at an edge: state SHALL become CLEAR with latched colour 0 and counter 0; mapa_vld=0, mapa_cor=0, wr_ready=0, busy=1 from the next cycle.
REQ-019 A reset asserted mid-sweep or mid-read SHALL abandon it; the pending mapa_vld SHALL not appear.
REQ-020 After reset release the map SHALL read all-zero once busy falls.

Structure
REQ-021 MAP_W, MAP_H, COLOR_BITS defaults and the FSM state encoding SHALL live in a shared package also used by renderer and game logic.
REQ-022 Storage SHALL be one sub-module mapa_ram (1 read port, 1 write port, registered read), inferable as block RAM; FSM, range checks and write-port mux (sweep has priority over wr path, which is already blocked) stay in mapa_mem.

Verification
REQ-023 Reset low 1 cycle, release -> busy high exactly 1200 cycles, then wr_ready=1; read (39,29) -> 0.
REQ-024 Write (5,3)=0x2A in IDLE; read (5,3) next cycle -> mapa_cor=0x2A, mapa_vld high exactly one cycle after the read strobe.
REQ-025 Same-cycle write (7,7)=0x11 over 0x05 and read (7,7) -> 0x05; following read -> 0x11.
REQ-026 Read (40,0) and (0,30) -> 0 with mapa_vld=1; write (40,0)=0x3F -> wr_ready handshake completes, cell (0,1) unchanged.
REQ-027 clr_req with 0x15; at sweep cycle 600 clr_req with 0x0A -> busy lasts 600+1200 cycles, all cells read 0x0A; wr_en during sweep -> not accepted, no change.
REQ-028 reset_n low during a sweep at cell 300 -> restart at cell 0 with colour 0, no mapa_vld for the in-flight read.

Source files
------------

// File: rtl/mapa_mem_pkg.sv
// Shared map constants and FSM encoding for the block map, renderer and game logic.
package mapa_mem_pkg;

  localparam int unsigned MAP_W_DEF      = 40;
  localparam int unsigned MAP_H_DEF      = 30;
  localparam int unsigned COLOR_BITS_DEF = 6;
  localparam int unsigned COORD_W        = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } mapa_state_t;

endpackage

// File: rtl/mapa_mem_ram.sv
// Simple dual-port map storage: one write port, one registered read port with
// a synchronous zeroing control on the output register.
module mapa_ram
  import mapa_mem_pkg::*;
#(
  parameter int unsigned DEPTH = MAP_W_DEF * MAP_H_DEF,
  parameter int unsigned AW    = $clog2(MAP_W_DEF * MAP_H_DEF),
  parameter int unsigned DW    = COLOR_BITS_DEF
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic          rd_zero,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register holds between reads; a same-cycle write is not forwarded.
  always_ff @(posedge clk) begin
    if (rd_zero) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mapa_mem.sv
// Block colour map: 1-cycle renderer reads, game-logic writes, and a
// cell-per-cycle fill sweep that also runs out of reset.
module mapa_mem
  import mapa_mem_pkg::*;
#(
  parameter int unsigned MAP_W      = MAP_W_DEF,
  parameter int unsigned MAP_H      = MAP_H_DEF,
  parameter int unsigned COLOR_BITS = COLOR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [COORD_W-1:0]    mapa_x,
  input  logic [COORD_W-1:0]    mapa_y,
  input  logic                  mapa_read,
  output logic [COLOR_BITS-1:0] mapa_cor,
  output logic                  mapa_vld,
  input  logic                  wr_en,
  input  logic [COORD_W-1:0]    wr_x,
  input  logic [COORD_W-1:0]    wr_y,
  input  logic [COLOR_BITS-1:0] wr_cor,
  output logic                  wr_ready,
  input  logic                  clr_req,
  input  logic [COLOR_BITS-1:0] clr_cor,
  output logic                  busy
);

  localparam int unsigned CELLS = MAP_W * MAP_H;
  localparam int unsigned IDX_W = $clog2(CELLS);
  localparam int unsigned LIN_W = 2 * COORD_W;

  mapa_state_t           state, state_nxt;
  logic [IDX_W-1:0]      cnt, cnt_nxt;
  logic [COLOR_BITS-1:0] fill, fill_nxt;

  logic                  rd_in_range, wr_in_range;
  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic                  ram_we;
  logic [IDX_W-1:0]      ram_waddr;
  logic [COLOR_BITS-1:0] ram_wdata;
  logic                  ram_rd_en, ram_rd_zero;

  assign rd_in_range = (mapa_x < COORD_W'(MAP_W)) && (mapa_y < COORD_W'(MAP_H));
  assign wr_in_range = (wr_x < COORD_W'(MAP_W)) && (wr_y < COORD_W'(MAP_H));
  assign rd_idx = IDX_W'(LIN_W'(mapa_y) * LIN_W'(MAP_W) + LIN_W'(mapa_x));
  assign wr_idx = IDX_W'(LIN_W'(wr_y) * LIN_W'(MAP_W) + LIN_W'(wr_x));

  // Out-of-range reads zero the output register instead of touching memory.
  assign ram_rd_en   = reset_n & mapa_read & rd_in_range;
  assign ram_rd_zero = ~reset_n | (mapa_read & ~rd_in_range);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      cnt      <= '0;
      fill     <= '0;
      busy     <= 1'b1;
      wr_ready <= 1'b0;
      mapa_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      fill     <= fill_nxt;
      busy     <= (state_nxt == ST_CLEAR);
      wr_ready <= (state_nxt == ST_IDLE);
      mapa_vld <= mapa_read;
    end
  end

  // Next-state logic and write-port mux; the sweep owns the port while clearing.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fill_nxt  = fill;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (wr_en && wr_in_range) begin
          ram_we    = reset_n;
          ram_waddr = wr_idx;
          ram_wdata = wr_cor;
        end
        if (clr_req) begin
          fill_nxt  = clr_cor;
          cnt_nxt   = '0;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        ram_we    = reset_n;
        ram_waddr = cnt;
        ram_wdata = fill;
        if (clr_req) begin
          fill_nxt = clr_cor;
          cnt_nxt  = '0;
        end else if (cnt == IDX_W'(CELLS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + IDX_W'(1);
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  mapa_ram #(
    .DEPTH(CELLS),
    .AW   (IDX_W),
    .DW   (COLOR_BITS)
  ) u_ram (
    .clk    (clk),
    .rd_en  (ram_rd_en),
    .rd_zero(ram_rd_zero),
    .rd_addr(rd_idx),
    .rd_data(mapa_cor),
    .wr_en  (ram_we),
    .wr_addr(ram_waddr),
    .wr_data(ram_wdata)
  );

endmodule
